mmio_initiator: RTL and testbench

- Bus master for the on-chip peripheral port: address/data/rden/wren/clken out, registered q back.
- Accepts one command at a time over a valid/ready interface (WRITE, READ, POLL) and issues the matching peripheral access.
- Returns a single response per command over a valid/ready interface.
- Sits between a controller (CPU shim or test sequencer) and a peripheral such as the GPIO block.

---
 rtl/mmio_initiator.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_initiator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_initiator.sv
// rtl/mmio_initiator.sv - single-command MMIO bus master (WRITE/READ/POLL, RMW op under MMIO_INIT_RMW_EN)
module mmio_initiator #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 10,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [WIDTH-1:0]     cmd_wdata,
  input  logic [WIDTH-1:0]     cmd_mask,
  input  logic [TIMEOUT_W-1:0] cmd_timeout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_W-1:0]    bus_address,
  output logic [WIDTH-1:0]     bus_data,
  output logic                 bus_rden,
  output logic                 bus_wren,
  output logic                 bus_clken,
  input  logic [WIDTH-1:0]     bus_q
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_RMW   = 2'd3;

  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_POLL_ISSUE,
    S_POLL_WAIT,
`ifdef MMIO_INIT_RMW_EN
    S_RMW_RD,
    S_RMW_WAIT,
    S_RMW_WR,
`endif
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    bus_address_q, bus_address_d;
  logic [WIDTH-1:0]     bus_data_q, bus_data_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 bus_rden_q, bus_rden_d;
  logic                 bus_wren_q, bus_wren_d;
  logic                 bus_clken_q, bus_clken_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 poll_match;

  // Masked compare of the returned word against the expected value.
  assign poll_match = ((bus_q & mask_q) == (wdata_q & mask_q));

`ifdef MMIO_INIT_RMW_EN
  logic [WIDTH-1:0] rmw_merge;
  // Keep bits outside the field mask, replace bits inside it.
  assign rmw_merge = (bus_q & ~mask_q) | (wdata_q & mask_q);
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign bus_address = bus_address_q;
  assign bus_data    = bus_data_q;
  assign bus_rden    = bus_rden_q;
  assign bus_wren    = bus_wren_q;
  assign bus_clken   = bus_clken_q;

  // Next-state, datapath and registered-output decode; strobes derive from the next state.
  always_comb begin
    state_d       = state_q;
    bus_address_d = bus_address_q;
    bus_data_d    = bus_data_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          bus_address_d = cmd_addr;
          bus_data_d    = cmd_wdata;
          wdata_d       = cmd_wdata;
          mask_d        = cmd_mask;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          case (cmd_op)
            OP_WRITE: state_d = S_WR;
            OP_READ:  state_d = S_RD_ISSUE;
            OP_POLL: begin
              state_d = S_POLL_ISSUE;
              cnt_d   = (cmd_timeout == '0) ? CNT_ONE : cmd_timeout;
            end
            OP_RMW: begin
`ifdef MMIO_INIT_RMW_EN
              state_d = S_RMW_RD;
`else
              state_d   = S_RESP;
              rsp_err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      S_WR:       state_d = S_RESP;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rsp_rdata_d = bus_q;
        state_d     = S_RESP;
      end
      S_POLL_ISSUE: state_d = S_POLL_WAIT;
      S_POLL_WAIT: begin
        rsp_rdata_d = bus_q;
        if (poll_match) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d = S_POLL_ISSUE;
          end
        end
      end
`ifdef MMIO_INIT_RMW_EN
      S_RMW_RD: state_d = S_RMW_WAIT;
      S_RMW_WAIT: begin
        rsp_rdata_d = bus_q;
        bus_data_d  = rmw_merge;
        state_d     = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_RESP;
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    bus_rden_d = (state_d == S_RD_ISSUE) || (state_d == S_POLL_ISSUE)
`ifdef MMIO_INIT_RMW_EN
                 || (state_d == S_RMW_RD)
`endif
                 ;
    bus_wren_d = (state_d == S_WR)
`ifdef MMIO_INIT_RMW_EN
                 || (state_d == S_RMW_WR)
`endif
                 ;
    bus_clken_d = bus_rden_d || bus_wren_d;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      bus_address_q <= '0;
      bus_data_q    <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      cnt_q         <= '0;
      bus_rden_q    <= 1'b0;
      bus_wren_q    <= 1'b0;
      bus_clken_q   <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      cnt_q         <= cnt_d;
      bus_rden_q    <= bus_rden_d;
      bus_wren_q    <= bus_wren_d;
      bus_clken_q   <= bus_clken_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_mmio_initiator.sv
// tb/tb_mmio_initiator.sv - directed self-checking bench for mmio_initiator
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [9:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic [15:0] cmd_timeout = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  bus_address;
  logic [31:0] bus_data;
  logic        bus_rden;
  logic        bus_wren;
  logic        bus_clken;
  logic [31:0] bus_q = '0;

  int checks = 0;
  int passed = 0;

  // Responder state: mem/mode written by the stimulus, counters by the responder only.
  logic [31:0] mem [0:1023];
  int          resp_mode  = 0;
  int          poll_base  = 0;
  int          poll_hi_at = 0;
  int          rd_count   = 0;
  int          wr_count   = 0;
  logic [9:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  mmio_initiator #(.WIDTH(32), .ADDR_W(10), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .cmd_timeout(cmd_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_address(bus_address), .bus_data(bus_data), .bus_rden(bus_rden),
    .bus_wren(bus_wren), .bus_clken(bus_clken), .bus_q(bus_q)
  );

  always #5 clk = ~clk;

  // Peripheral model: registered read data, write capture, strobe counters.
  always @(posedge clk) begin
    if (bus_clken && bus_rden) begin
      if (resp_mode == 0) bus_q <= mem[bus_address];
      else bus_q <= ((poll_hi_at != 0) && (rd_count - poll_base + 1 >= poll_hi_at)) ? 32'h1 : 32'h0;
      rd_count <= rd_count + 1;
    end
    if (bus_clken && bus_wren) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= bus_address;
      last_wr_data <= bus_data;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask,
                          input logic [15:0] tmo);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL send_ready: cmd_ready=%b want 1", cmd_ready);
    else passed++;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_wdata = wdata; cmd_mask = mask; cmd_timeout = tmo;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus_rden, bus_wren, bus_clken} !== 3'b000)
      $display("FAIL reset_strobes: rden/wren/clken=%b want 000", {bus_rden, bus_wren, bus_clken});
    else passed++;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    else passed++;
    checks++;
    if (bus_address !== 10'h0 || bus_data !== 32'h0)
      $display("FAIL reset_bus: addr=%h data=%h want 0/0", bus_address, bus_data);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
    else passed++;
  endtask

  task automatic test_write();
    int wbase, lat;
    wbase = wr_count;
    rsp_ready = 1'b1;
    send_cmd(2'd0, 10'h000, 32'hA5A5A5A5, 32'h0, 16'h0);
    checks++;
    if ({bus_wren, bus_clken, bus_rden} !== 3'b110 || bus_address !== 10'h0 || bus_data !== 32'hA5A5A5A5)
      $display("FAIL wr_strobe: wren/clken/rden=%b addr=%h data=%h want 110/000/a5a5a5a5",
               {bus_wren, bus_clken, bus_rden}, bus_address, bus_data);
    else passed++;
    wait_rsp(lat);
    checks++;
    if (lat != 1) $display("FAIL wr_latency: got %0d want 1", lat);
    else passed++;
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || bus_wren !== 1'b0)
      $display("FAIL wr_rsp: rdata=%h err=%b wren=%b want 0/0/0", rsp_rdata, rsp_err, bus_wren);
    else passed++;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL wr_after: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
    else passed++;
    checks++;
    if (wr_count - wbase != 1 || last_wr_data !== 32'hA5A5A5A5)
      $display("FAIL wr_count: writes=%0d data=%h want 1/a5a5a5a5", wr_count - wbase, last_wr_data);
    else passed++;
  endtask

  task automatic test_read();
    int rbase, lat;
    resp_mode = 0;
    mem[4] = 32'h12345678;
    rbase = rd_count;
    rsp_ready = 1'b0;
    send_cmd(2'd1, 10'h004, 32'h0, 32'h0, 16'h0);
    checks++;
    if ({bus_rden, bus_clken, bus_wren} !== 3'b110 || bus_address !== 10'h004)
      $display("FAIL rd_strobe: rden/clken/wren=%b addr=%h want 110/004", {bus_rden, bus_clken, bus_wren}, bus_address);
    else passed++;
    wait_rsp(lat);
    checks++;
    if (lat != 2) $display("FAIL rd_latency: got %0d want 2", lat);
    else passed++;
    checks++;
    if (rsp_rdata !== 32'h12345678 || rsp_err !== 1'b0)
      $display("FAIL rd_data: rdata=%h err=%b want 12345678/0", rsp_rdata, rsp_err);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || cmd_ready !== 1'b0)
        $display("FAIL rd_hold%0d: valid=%b rdata=%h ready=%b want 1/12345678/0", i, rsp_valid, rsp_rdata, cmd_ready);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL rd_release: valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    else passed++;
    checks++;
    if (rd_count - rbase != 1) $display("FAIL rd_pulses: got %0d want 1", rd_count - rbase);
    else passed++;
  endtask

  task automatic test_poll_match();
    int rbase, lat;
    resp_mode = 1; poll_hi_at = 3; poll_base = rd_count;
    rbase = rd_count;
    send_cmd(2'd2, 10'h004, 32'h1, 32'h1, 16'd8);
    wait_rsp(lat);
    checks++;
    if (lat != 6) $display("FAIL poll_latency: got %0d want 6", lat);
    else passed++;
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h1)
      $display("FAIL poll_match: err=%b rdata=%h want 0/00000001", rsp_err, rsp_rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (rd_count - rbase != 3) $display("FAIL poll_pulses: got %0d want 3", rd_count - rbase);
    else passed++;
  endtask

  task automatic test_op3();
    int rbase, wbase, lat;
    resp_mode = 0;
    mem[16] = 32'hFF00FF00;
    rbase = rd_count; wbase = wr_count;
    send_cmd(2'd3, 10'h010, 32'h00001234, 32'h0000FFFF, 16'h0);
    wait_rsp(lat);
`ifdef MMIO_INIT_RMW_EN
    checks++;
    if (lat != 3) $display("FAIL rmw_latency: got %0d want 3", lat);
    else passed++;
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'hFF00FF00)
      $display("FAIL rmw_rsp: err=%b rdata=%h want 0/ff00ff00", rsp_err, rsp_rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (last_wr_data !== 32'hFF001234 || last_wr_addr !== 10'h010)
      $display("FAIL rmw_write: data=%h addr=%h want ff001234/010", last_wr_data, last_wr_addr);
    else passed++;
    checks++;
    if (rd_count - rbase != 1 || wr_count - wbase != 1)
      $display("FAIL rmw_pulses: reads=%0d writes=%0d want 1/1", rd_count - rbase, wr_count - wbase);
    else passed++;
`else
    checks++;
    if (lat != 0) $display("FAIL op3_latency: got %0d want 0", lat);
    else passed++;
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL op3_rsp: err=%b rdata=%h want 1/00000000", rsp_err, rsp_rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (rd_count - rbase != 0 || wr_count - wbase != 0)
      $display("FAIL op3_pulses: reads=%0d writes=%0d want 0/0", rd_count - rbase, wr_count - wbase);
    else passed++;
`endif
  endtask

  task automatic test_poll_timeout();
    int rbase, lat;
    resp_mode = 1; poll_hi_at = 0;
    rbase = rd_count;
    send_cmd(2'd2, 10'h004, 32'h1, 32'h1, 16'd4);
    wait_rsp(lat);
    checks++;
    if (lat != 8 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL poll_to4: lat=%0d err=%b rdata=%h want 8/1/0", lat, rsp_err, rsp_rdata);
    else passed++;
    @(negedge clk);
    checks++;
    if (rd_count - rbase != 4) $display("FAIL poll_to4_pulses: got %0d want 4", rd_count - rbase);
    else passed++;
    rbase = rd_count;
    send_cmd(2'd2, 10'h004, 32'h1, 32'h1, 16'd0);
    wait_rsp(lat);
    checks++;
    if (lat != 2 || rsp_err !== 1'b1)
      $display("FAIL poll_to0: lat=%0d err=%b want 2/1", lat, rsp_err);
    else passed++;
    @(negedge clk);
    checks++;
    if (rd_count - rbase != 1) $display("FAIL poll_to0_pulses: got %0d want 1", rd_count - rbase);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int rbase;
    resp_mode = 0;
    rbase = rd_count;
    send_cmd(2'd1, 10'h004, 32'h0, 32'h0, 16'h0);
    checks++;
    if (bus_rden !== 1'b1) $display("FAIL mid_active: rden=%b want 1", bus_rden);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus_rden, bus_wren, bus_clken, rsp_valid} !== 4'b0000)
      $display("FAIL mid_abort: rden/wren/clken/valid=%b want 0000", {bus_rden, bus_wren, bus_clken, rsp_valid});
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || bus_rden !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL mid_quiet%0d: valid=%b rden=%b ready=%b want 0/0/1", i, rsp_valid, bus_rden, cmd_ready);
      else passed++;
    end
    checks++;
    if (rd_count - rbase != 0) $display("FAIL mid_pulses: got %0d want 0", rd_count - rbase);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int wbase;
    logic [5:0] exp_w;
    logic [5:0] exp_r;
    exp_w = 6'b001001;
    exp_r = 6'b100100;
    wbase = wr_count;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 10'h008; cmd_wdata = 32'h0000005A;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus_wren !== exp_w[i] || cmd_ready !== exp_r[i])
        $display("FAIL b2b_cyc%0d: wren=%b ready=%b want %b/%b", i, bus_wren, cmd_ready, exp_w[i], exp_r[i]);
      else passed++;
      if (i == 5) cmd_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (wr_count - wbase != 2) $display("FAIL b2b_writes: got %0d want 2", wr_count - wbase);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll_match();
    test_op3();
    test_poll_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
